// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: address/data phase cycle generator for the RTC multiplexed bus.
// Define RTC_WRITE_VERIFY_EN to read back every write and flag mismatches on wr_err.
module rtc_bus_sequencer #(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_PULSE = 7,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_GAP   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       win,
   input  logic       rin,
   input  logic [7:0] address,
   input  logic [7:0] data_w,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       a_d_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] data_r,
   output logic       donew,
   output logic       doner,
   output logic       busy,
   output logic       wr_err
);
   localparam logic [3:0] IDLE = 4'd0, AS = 4'd1, AP = 4'd2, AH = 4'd3, G1 = 4'd4;
   localparam logic [3:0] DS = 4'd5, DP = 4'd6, DH = 4'd7, DONE = 4'd8, REC = 4'd9;
`ifdef RTC_WRITE_VERIFY_EN
   localparam logic [3:0] VG = 4'd10;
`endif
   localparam logic [3:0] C_S = 4'(T_SETUP - 1);
   localparam logic [3:0] C_P = 4'(T_PULSE - 1);
   localparam logic [3:0] C_H = 4'(T_HOLD - 1);
   localparam logic [3:0] C_G = 4'(T_GAP - 1);
   logic [3:0] st, ns, cnt, nc;
   logic [7:0] addr_l, data_l, na, nd;
   logic       rd, nrd, vfy, nvfy, last, aph, cs_on, oe_nx;
`ifndef RTC_WRITE_VERIFY_EN
   assign vfy    = 1'b0;
   assign wr_err = 1'b0;
`endif
   assign last = cnt == 4'd0;
   always_comb begin
      ns   = st;
      nc   = cnt - 4'd1;
      nrd  = rd;
      nvfy = vfy;
      na   = addr_l;
      nd   = data_l;
      case (st)
         IDLE: if (win | rin) begin
            ns   = AS;
            nc   = C_S;
            nrd  = ~win;
            nvfy = 1'b0;
            na   = address;
            nd   = data_w;
         end
         AS: if (last) begin ns = AP; nc = C_P; end
         AP: if (last) begin ns = AH; nc = C_H; end
         AH: if (last) begin ns = G1; nc = C_G; end
         G1: if (last) begin ns = DS; nc = C_S; end
`ifdef RTC_WRITE_VERIFY_EN
         VG: if (last) begin ns = AS; nc = C_S; end
`endif
         DS: if (last) begin ns = DP; nc = C_P; end
         DP: if (last) begin ns = DH; nc = C_H; end
         DH: if (last) begin
`ifdef RTC_WRITE_VERIFY_EN
            // a finished write data phase turns into a read-back of the same address
            if (!rd) begin ns = VG; nc = C_G; nrd = 1'b1; nvfy = 1'b1; end else
`endif
            begin ns = DONE; nc = 4'd0; end
         end
         DONE: begin ns = REC; nc = C_G; end
         REC: if (last) ns = IDLE;
         default: ns = IDLE;
      endcase
   end
   assign aph   = ns inside {AS, AP, AH};
   assign cs_on = aph | (ns inside {DS, DP, DH});
   assign oe_nx = aph | (!nrd & (ns inside {G1, DS, DP, DH}));
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st     <= IDLE;
         cnt    <= 4'd0;
         addr_l <= 8'h00;
         data_l <= 8'h00;
         rd     <= 1'b0;
         ad_out <= 8'h00;
         ad_oe  <= 1'b0;
         cs_n   <= 1'b1;
         a_d_n  <= 1'b1;
         wr_n   <= 1'b1;
         rd_n   <= 1'b1;
         data_r <= 8'h00;
         donew  <= 1'b0;
         doner  <= 1'b0;
         busy   <= 1'b0;
`ifdef RTC_WRITE_VERIFY_EN
         vfy    <= 1'b0;
         wr_err <= 1'b0;
`endif
      end else begin
         st     <= ns;
         cnt    <= nc;
         addr_l <= na;
         data_l <= nd;
         rd     <= nrd;
         ad_out <= oe_nx ? (aph ? na : nd) : 8'h00;
         ad_oe  <= oe_nx;
         cs_n   <= ~cs_on;
         a_d_n  <= ~aph;
         wr_n   <= ~((ns == AP) | ((ns == DP) & !nrd));
         rd_n   <= ~((ns == DP) & nrd);
         donew  <= (ns == DONE) & (!nrd | nvfy);
         doner  <= (ns == DONE) & nrd & !nvfy;
         busy   <= ns != IDLE;
`ifdef RTC_WRITE_VERIFY_EN
         vfy    <= nvfy;
`endif
         if (st == DP && last && rd)
`ifdef RTC_WRITE_VERIFY_EN
            if (vfy) wr_err <= ad_in != data_l; else
`endif
            data_r <= ad_in;
      end
   end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed vector table plus hand sequences for request overlap, held requests and mid-transaction reset.
module tb_rtc_bus_sequencer;
   localparam int TS = 2, TP = 7, TH = 2, TG = 4;
   localparam int BASE = 2 * (TS + TP + TH) + TG + 1;
`ifdef RTC_WRITE_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif
   localparam int LAT_W = VER ? BASE + TG + BASE - 1 : BASE;
   typedef struct {
      logic       w, r;
      logic [7:0] a, d, bus, dr;
      logic       err;
   } vec_t;
   logic       clock = 1'b0, reset = 1'b1, win = 1'b0, rin = 1'b0;
   logic [7:0] address = 8'h00, data_w = 8'h00, bus_val = 8'h00, ad_in;
   logic [7:0] ad_out, data_r;
   logic       ad_oe, cs_n, a_d_n, wr_n, rd_n, donew, doner, busy, wr_err;
   int n_run = 0, n_fail = 0;
   vec_t vt[7];
   always #5 clock = ~clock;
   assign ad_in = !rd_n ? bus_val : 8'h5A;
   rtc_bus_sequencer #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)) dut (
      .clock(clock), .reset(reset), .win(win), .rin(rin), .address(address), .data_w(data_w),
      .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .a_d_n(a_d_n), .wr_n(wr_n),
      .rd_n(rd_n), .data_r(data_r), .donew(donew), .doner(doner), .busy(busy), .wr_err(wr_err)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic run(input int idx, input vec_t v);
      int lat = 0, rec = 0, aw = 0, dwn = 0, rdn = 0, bad = 0, ndw = 0, ndr = 0;
      logic [7:0] as = 8'h00, ds = 8'h00;
      bit rd = v.r && !v.w;
      bit vw = VER && !rd;
      @(negedge clock);
      win = v.w; rin = v.r; address = v.a; data_w = v.d; bus_val = v.bus;
      for (int c = 1; c <= 200 && rec == 0; c++) begin
         @(negedge clock);
         if (c == 1) begin
            chk($sformatf("v%0d first_cycle", idx), {cs_n, a_d_n, wr_n, ad_oe}, 4'b0011);
            win = 1'b0; rin = 1'b0; address = ~v.a; data_w = ~v.d;
         end
         if (!a_d_n && !wr_n) begin aw++; as = ad_out; end
         if (a_d_n && !wr_n) begin dwn++; ds = ad_out; end
         if (!rd_n) rdn++;
         if ((!rd_n && ad_oe) || (!busy && !cs_n) || (rd && a_d_n && !cs_n && ad_oe)) bad++;
         if ((donew || doner) && lat == 0) lat = c;
         ndw += int'(donew);
         ndr += int'(doner);
         if (lat != 0 && !busy) rec = c - lat;
      end
      chk($sformatf("v%0d done_cycle", idx), lat, rd ? BASE : LAT_W);
      chk($sformatf("v%0d addr_strobe_len", idx), aw, vw ? 2 * TP : TP);
      chk($sformatf("v%0d addr_value", idx), as, v.a);
      chk($sformatf("v%0d wr_data_strobe_len", idx), dwn, rd ? 0 : TP);
      chk($sformatf("v%0d rd_strobe_len", idx), rdn, (rd || vw) ? TP : 0);
      if (!rd) chk($sformatf("v%0d write_data", idx), ds, v.d);
      chk($sformatf("v%0d bus_rule_violations", idx), bad, 0);
      chk($sformatf("v%0d donew_pulses", idx), ndw, rd ? 0 : 1);
      chk($sformatf("v%0d doner_pulses", idx), ndr, rd ? 1 : 0);
      chk($sformatf("v%0d rec_cycles", idx), rec, TG + 1);
      chk($sformatf("v%0d data_r", idx), data_r, v.dr);
      chk($sformatf("v%0d wr_err", idx), wr_err, VER ? v.err : 1'b0);
   endtask
   initial begin
      int tw, tr, nw, nr, n, cyc;
      bit hit;
      logic [7:0] seen[3];
      vec_t pv;
      vt[0] = '{w:1'b1, r:1'b0, a:8'h21, d:8'h45, bus:8'h45, dr:8'h00, err:1'b0};
      vt[1] = '{w:1'b0, r:1'b1, a:8'h26, d:8'h00, bus:8'h17, dr:8'h17, err:1'b0};
      vt[2] = '{w:1'b1, r:1'b0, a:8'h22, d:8'h33, bus:8'h33, dr:8'h17, err:1'b0};
      vt[3] = '{w:1'b1, r:1'b0, a:8'h22, d:8'h33, bus:8'h30, dr:8'h17, err:1'b1};
      vt[4] = '{w:1'b0, r:1'b1, a:8'h80, d:8'h11, bus:8'hC3, dr:8'hC3, err:1'b1};
      vt[5] = '{w:1'b1, r:1'b0, a:8'h5A, d:8'hA5, bus:8'hA5, dr:8'hC3, err:1'b0};
      vt[6] = '{w:1'b0, r:1'b1, a:8'h00, d:8'h00, bus:8'hFF, dr:8'hFF, err:1'b0};
      #12;
      chk("reset_outputs", {ad_out, ad_oe, cs_n, a_d_n, wr_n, rd_n, data_r, donew, doner, busy, wr_err},
          {8'h00, 1'b0, 4'b1111, 8'h00, 4'b0000});
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) run(i, vt[i]);
      // write and read requested together: write first, the held read follows after recovery
      @(negedge clock);
      win = 1'b1; rin = 1'b1; address = 8'hF1; data_w = 8'h3C; bus_val = 8'h3C;
      tw = 0; tr = 0; nw = 0; nr = 0;
      for (int c = 1; c <= 300 && tr == 0; c++) begin
         @(negedge clock);
         if (c == 1) win = 1'b0;
         if (donew) begin nw++; if (tw == 0) tw = c; end
         if (doner) begin nr++; tr = c; rin = 1'b0; end
      end
      chk("both_write_done_cycle", tw, LAT_W);
      chk("both_read_done_cycle", tr, LAT_W + TG + 1 + BASE);
      chk("both_pulse_counts", {nw[7:0], nr[7:0]}, 16'h0101);
      chk("both_data_r", data_r, 8'h3C);
      // win held high across three transactions, address advanced after each donew
      @(negedge clock);
      win = 1'b1; address = 8'h10; data_w = 8'h77; bus_val = 8'h77;
      n = 0; seen[0] = 8'h00; seen[1] = 8'h00; seen[2] = 8'h00;
      for (int c = 1; c <= 260; c++) begin
         @(negedge clock);
         if (!a_d_n && !wr_n && n < 3) seen[n] = ad_out;
         if (donew) begin
            n++;
            address = 8'h10 + 8'(n);
            if (n == 3) win = 1'b0;
         end
      end
      chk("held_win_donew_count", n, 3);
      for (int i = 0; i < 3; i++) chk($sformatf("held_win_addr%0d", i), seen[i], 8'h10 + 8'(i));
      // reset in the middle of a write data strobe
      @(negedge clock);
      win = 1'b1; address = 8'h44; data_w = 8'h99; bus_val = 8'h99;
      hit = 1'b0;
      for (int c = 1; c <= 100 && !hit; c++) begin
         @(negedge clock);
         win = 1'b0;
         hit = a_d_n && !wr_n;
      end
      chk("reached_data_strobe", hit, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_outputs", {ad_out, ad_oe, cs_n, a_d_n, wr_n, rd_n, data_r, donew, doner, busy, wr_err},
          {8'h00, 1'b0, 4'b1111, 8'h00, 4'b0000});
      @(negedge clock);
      reset = 1'b0;
      cyc = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (busy || donew || doner) cyc++;
      end
      chk("no_activity_after_reset", cyc, 0);
      pv = '{w:1'b1, r:1'b0, a:8'h45, d:8'h9A, bus:8'h9A, dr:8'h00, err:1'b0};
      run(7, pv);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
